// File: rtl/effect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | effect_pkg: shared types, constants and level table for the effects. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package effect_pkg;

  localparam logic [15:0] GAIN_UNITY = 16'hFFFF;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } exp_state_t;

  typedef struct packed {
    logic [15:0] thr;
    logic [15:0] flr;
  } level_cfg_t;

  function automatic level_cfg_t level_cfg(input logic [2:0] level);
    level_cfg_t cfg;
    case (level)
      3'd0:    cfg = '{thr: 16'd128,  flr: 16'hC000};
      3'd1:    cfg = '{thr: 16'd256,  flr: 16'hA000};
      3'd2:    cfg = '{thr: 16'd512,  flr: 16'h8000};
      3'd3:    cfg = '{thr: 16'd1024, flr: 16'h4000};
      3'd4:    cfg = '{thr: 16'd1536, flr: 16'h2000};
      3'd5:    cfg = '{thr: 16'd2048, flr: 16'h1000};
      3'd6:    cfg = '{thr: 16'd3072, flr: 16'h0400};
      default: cfg = '{thr: 16'd4096, flr: 16'h0000};
    endcase
    return cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/effect_env_follower.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | effect_env_follower: saturating abs and one-pole envelope follower.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module effect_env_follower
  import effect_pkg::*;
#(
  parameter int ENV_SHIFT = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  output logic [15:0] o_env
);

  logic [15:0]        env_q;
  logic [15:0]        env_d;
  logic [15:0]        abs_val;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [16:0] sum;
  logic               unused_sum;

  // -32768 has no positive twin in 16 bits, so it clips to 32767
  assign abs_val = (i_data == 16'h8000) ? 16'h7FFF :
                   (i_data[15] ? 16'(-i_data) : i_data);

  assign diff       = $signed({1'b0, abs_val}) - $signed({1'b0, env_q});
  assign step       = diff >>> ENV_SHIFT;
  assign sum        = $signed({1'b0, env_q}) + step;
  assign unused_sum = sum[16];

  always_comb begin
    env_d = env_q;
    if (i_valid) begin
      env_d = sum[15:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      env_q <= '0;
    end else begin
      env_q <= env_d;
    end
  end

  assign o_env = env_q;

endmodule
`default_nettype wire

// File: rtl/effect_expander.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | effect_expander: downward expander with hold timer and asymmetric    |
// | attack/release gain smoothing. EXPANDER_HYST_EN adds close hysteresis.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module effect_expander
  import effect_pkg::*;
#(
  parameter int HOLD_SAMPLES  = 1024,
  parameter int ENV_SHIFT     = 7,
  parameter int ATTACK_SHIFT  = 4,
  parameter int RELEASE_SHIFT = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid
);

  localparam int CNT_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_SAMPLES - 1);

  exp_state_t         state_q, state_d;
  logic [15:0]        gain_q, gain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [15:0] data_q, data_d;
  logic               valid_q, valid_d;

  logic [15:0]        env;
  level_cfg_t         cfg;
  logic [15:0]        thr_open;
  logic [15:0]        thr_close;
  logic [15:0]        up_raw, up_step;
  logic [15:0]        down_raw, down_step;
  logic signed [16:0] gain_s;
  logic signed [32:0] prod;
  logic               unused_prod;

  effect_env_follower #(
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_env   (env)
  );

  assign cfg      = level_cfg(i_level);
  assign thr_open = cfg.thr;
`ifdef EXPANDER_HYST_EN
  assign thr_close = cfg.thr - (cfg.thr >> 2);
`else
  assign thr_close = cfg.thr;
`endif

  // Smoothing steps never stall short of their target: a zero step becomes one
  assign up_raw    = (GAIN_UNITY - gain_q) >> ATTACK_SHIFT;
  assign up_step   = (up_raw == 16'd0 && gain_q != GAIN_UNITY) ? 16'd1 : up_raw;
  assign down_raw  = (gain_q - cfg.flr) >> RELEASE_SHIFT;
  assign down_step = (down_raw == 16'd0 && gain_q != cfg.flr) ? 16'd1 : down_raw;

  assign gain_s      = $signed({1'b0, gain_q});
  assign prod        = i_data * gain_s;
  assign unused_prod = ^{prod[32], prod[15:0]};

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = i_valid;
    if (i_valid) begin
      if (!i_enable) begin
        data_d  = i_data;
        state_d = OPEN;
        gain_d  = GAIN_UNITY;
        cnt_d   = '0;
      end else begin
        data_d = (gain_q == GAIN_UNITY) ? i_data : prod[31:16];
        case (state_q)
          OPEN: begin
            gain_d = gain_q + up_step;
            if (env < thr_close) begin
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
          HOLD: begin
            if (env >= thr_open) begin
              state_d = OPEN;
            end else if (cnt_q == '0) begin
              state_d = RELEASE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          RELEASE: begin
            // A level change can lift the floor above the current gain
            if (gain_q < cfg.flr) begin
              gain_d = cfg.flr;
            end else begin
              gain_d = gain_q - down_step;
            end
            if (env >= thr_open) begin
              state_d = OPEN;
            end
          end
          default: state_d = OPEN;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= OPEN;
      gain_q  <= GAIN_UNITY;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule
`default_nettype wire
